// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder stimulus/checker
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int OPW  = 8;
  localparam int SUMW = 9;
  localparam int IDXW = 16;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
    logic [SUMW-1:0] exp;
  } exp_entry_t;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [OPW-1:0] CORNER_A [4] = '{8'h00, 8'hFF, 8'hFF, 8'h80};
  localparam logic [OPW-1:0] CORNER_B [4] = '{8'h00, 8'hFF, 8'h01, 8'h80};

endpackage

// File: rtl/adder_stim_lfsr.sv
// rtl/adder_stim_lfsr.sv - 16-bit Fibonacci LFSR with seed load and advance enable
// A zero seed would lock the register, so it is replaced by 16'h0001.
module adder_stim_lfsr
  import adder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb    = ^(r_state & LFSR_TAPS);
  assign o_state = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SEED_EFF;
    end else if (i_load) begin
      r_state <= SEED_EFF;
    end else if (i_adv) begin
      r_state <= {r_state[14:0], w_fb};
    end
  end

endmodule

// File: rtl/adder_stim_checker.sv
// rtl/adder_stim_checker.sv - drives operand pairs to an 8-bit adder and checks the sums
// Optional ADDER_STIM_CORNER_EN: vectors 0..3 are fixed corner cases instead of LFSR values.
module adder_stim_checker
  import adder_pkg::*;
#(
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [OPW-1:0]  in1,
  output logic [OPW-1:0]  in2,
  input  logic [SUMW-1:0] out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [15:0]     first_err_idx
);

  localparam logic [15:0] N_LAST     = 16'(NUM_VECTORS);
  localparam logic [2:0]  DRAIN_LAST = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_e          r_state;
  state_e          w_next;
  logic [15:0]     r_cnt;
  logic [2:0]      r_drain;
  logic [OPW-1:0]  r_in1;
  logic [OPW-1:0]  r_in2;
  logic [15:0]     r_err;
  logic [15:0]     r_first;
  exp_entry_t      r_pipe [LATENCY];

  logic            w_issue;
  logic            w_start_ok;
  logic            w_corner;
  logic            w_adv;
  logic [15:0]     w_idx;
  logic [15:0]     w_lfsr;
  logic [OPW-1:0]  w_a;
  logic [OPW-1:0]  w_b;
  exp_entry_t      w_push;
  exp_entry_t      w_head;
  logic            w_mismatch;

  adder_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (1'b0),
    .i_adv   (w_adv),
    .o_state (w_lfsr)
  );

  // Vector 0 is issued on the same edge that accepts start.
  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_issue    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next     = RUN;
          w_start_ok = 1'b1;
          w_issue    = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == N_LAST) begin
          w_next = (LATENCY == 1) ? DONE : DRAIN;
        end else begin
          w_issue = 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_idx = w_start_ok ? 16'h0000 : r_cnt;

`ifdef ADDER_STIM_CORNER_EN
  assign w_corner = (w_idx < 16'd4);
`else
  assign w_corner = 1'b0;
`endif

  assign w_a   = w_corner ? CORNER_A[w_idx[1:0]] : w_lfsr[7:0];
  assign w_b   = w_corner ? CORNER_B[w_idx[1:0]] : w_lfsr[15:8];
  assign w_adv = w_issue && !w_corner;

  always_comb begin
    w_push       = '0;
    w_push.valid = w_issue;
    w_push.idx   = w_idx;
    w_push.exp   = {1'b0, w_a} + {1'b0, w_b};
  end

  assign w_head     = r_pipe[LATENCY-1];
  assign w_mismatch = w_head.valid && (out != w_head.exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_drain <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_err   <= '0;
      r_first <= 16'hFFFF;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_in1 <= w_a;
        r_in2 <= w_b;
        r_cnt <= w_idx + 16'd1;
      end else begin
        r_in1 <= '0;
        r_in2 <= '0;
      end

      r_drain <= (r_state == DRAIN) ? r_drain + 3'd1 : 3'd0;

      r_pipe[0] <= w_push;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (w_start_ok) begin
        r_err   <= '0;
        r_first <= 16'hFFFF;
      end else if (w_mismatch) begin
        if (r_err != 16'hFFFF) begin
          r_err <= r_err + 16'd1;
        end
        if (r_first == 16'hFFFF) begin
          r_first <= w_head.idx;
        end
      end
    end
  end

  assign in1           = r_in1;
  assign in2           = r_in2;
  assign busy          = (r_state == RUN) || (r_state == DRAIN);
  assign done          = (r_state == DONE);
  assign pass          = done && (r_err == 16'h0000);
  assign err_count     = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_adder_stim_checker.sv
// tb/tb_adder_stim_checker.sv - directed bench: four checker instances against ideal and faulty adders
module tb_adder_stim_checker;

  logic        clk;
  logic        rst_n;
  logic        start [4];
  logic [7:0]  in1   [4];
  logic [7:0]  in2   [4];
  logic        busy  [4];
  logic        done  [4];
  logic        pass  [4];
  logic [15:0] errc  [4];
  logic [15:0] ferr  [4];
  logic [8:0]  out0, out1, out2, out3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  cap_a [256];
  logic [7:0]  cap_b [256];
  logic [7:0]  ma    [256];
  logic [7:0]  mb    [256];
  logic [15:0] mstate [4];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
  } vec_t;
  vec_t tbl [5];

`ifdef ADDER_STIM_CORNER_EN
  localparam int COFF = 4;
`else
  localparam int COFF = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: ideal combinational, 1: ideal registered, 2: registered (wrong latency), 3: carry forced low
  assign out0 = {1'b0, in1[0]} + {1'b0, in2[0]};
  always_ff @(posedge clk) out1 <= {1'b0, in1[1]} + {1'b0, in2[1]};
  always_ff @(posedge clk) out2 <= {1'b0, in1[2]} + {1'b0, in2[2]};
  assign out3 = {1'b0, in1[3] + in2[3]};

  adder_stim_checker #(.LATENCY(1), .NUM_VECTORS(16), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start[0]), .in1(in1[0]), .in2(in2[0]), .out(out0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]), .first_err_idx(ferr[0]));
  adder_stim_checker #(.LATENCY(2), .NUM_VECTORS(256), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start[1]), .in1(in1[1]), .in2(in2[1]), .out(out1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]), .first_err_idx(ferr[1]));
  adder_stim_checker #(.LATENCY(1), .NUM_VECTORS(16), .SEED(16'hACE1)) u_dut2 (
    .clk(clk), .reset(rst_n), .start(start[2]), .in1(in1[2]), .in2(in2[2]), .out(out2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]), .first_err_idx(ferr[2]));
  adder_stim_checker #(.LATENCY(1), .NUM_VECTORS(8), .SEED(16'hACE1)) u_dut3 (
    .clk(clk), .reset(rst_n), .start(start[3]), .in1(in1[3]), .in2(in2[3]), .out(out3),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(errc[3]), .first_err_idx(ferr[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_vecs(input int u, input int n);
    logic [7:0] ca [4];
    logic [7:0] cb [4];
    ca = '{8'h00, 8'hFF, 8'hFF, 8'h80};
    cb = '{8'h00, 8'hFF, 8'h01, 8'h80};
    for (int k = 0; k < n; k++) begin
      if (COFF > 0 && k < 4) begin
        ma[k] = ca[k];
        mb[k] = cb[k];
      end else begin
        ma[k] = mstate[u][7:0];
        mb[k] = mstate[u][15:8];
        mstate[u] = lfsr_next(mstate[u]);
      end
    end
  endtask

  task automatic check_vecs(input int u, input int n);
    int bad;
    bad = 0;
    model_vecs(u, n);
    for (int k = 0; k < n; k++) begin
      if (cap_a[k] !== ma[k] || cap_b[k] !== mb[k]) bad++;
    end
    chk($sformatf("vec_seq_u%0d", u), bad, 0);
  endtask

  task automatic run(input int u, input int n, input int lat, input bit hold, output int de);
    de = -1;
    @(negedge clk);
    start[u] = 1'b1;
    for (int e = 0; e < n + lat + 8; e++) begin
      @(negedge clk);
      if (!hold) start[u] = 1'b0;
      if (e == 0) begin
        chk("busy_after_start", busy[u], 1);
        chk("err_cleared", errc[u], 0);
        chk("first_cleared", ferr[u], 16'hFFFF);
      end
      if (e < n) begin
        cap_a[e] = in1[u];
        cap_b[e] = in2[u];
      end
      if (done[u]) begin
        de = e;
        break;
      end
    end
    start[u] = 1'b0;
  endtask

  task automatic chk_reset_state(input int u);
    chk("rst_in1", in1[u], 0);
    chk("rst_in2", in2[u], 0);
    chk("rst_busy", busy[u], 0);
    chk("rst_done", done[u], 0);
    chk("rst_pass", pass[u], 0);
    chk("rst_err", errc[u], 0);
    chk("rst_first", ferr[u], 16'hFFFF);
  endtask

  initial begin
    int de;
    int carries;
    int first_carry;

    tbl[0] = '{a: 8'hE1, b: 8'hAC, s: 9'h18D};
    tbl[1] = '{a: 8'hC3, b: 8'h59, s: 9'h11C};
    tbl[2] = '{a: 8'h87, b: 8'hB3, s: 9'h13A};
    tbl[3] = '{a: 8'h0F, b: 8'h67, s: 9'h076};
    tbl[4] = '{a: 8'h1E, b: 8'hCE, s: 9'h0EC};

    for (int u = 0; u < 4; u++) begin
      start[u]  = 1'b0;
      mstate[u] = 16'hACE1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    rst_n = 1'b1;

    // combinational adder, LATENCY=1, N=16
    run(0, 16, 1, 1'b0, de);
    chk("l1_done_edge", de, 16);
    chk("l1_pass", pass[0], 1);
    chk("l1_err", errc[0], 0);
    chk("l1_first", ferr[0], 16'hFFFF);
    chk("l1_busy_done", busy[0], 0);
    chk("l1_idle_in1", in1[0], 0);
    check_vecs(0, 16);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tbl%0d_in1", i), cap_a[i + COFF], tbl[i].a);
      chk($sformatf("tbl%0d_in2", i), cap_b[i + COFF], tbl[i].b);
      chk($sformatf("tbl%0d_sum", i), {1'b0, cap_a[i + COFF]} + {1'b0, cap_b[i + COFF]}, tbl[i].s);
    end
`ifdef ADDER_STIM_CORNER_EN
    chk("corner1_in1", cap_a[1], 8'hFF);
    chk("corner2_in2", cap_b[2], 8'h01);
    chk("corner3_in1", cap_a[3], 8'h80);
`endif

    // restart from DONE with start held high throughout; sequence continues
    run(0, 16, 1, 1'b1, de);
    chk("hold_done_edge", de, 16);
    chk("hold_pass", pass[0], 1);
    check_vecs(0, 16);

    // registered adder, LATENCY=2, N=256
    run(1, 256, 2, 1'b0, de);
    chk("l2_done_edge", de, 257);
    chk("l2_pass", pass[1], 1);
    chk("l2_err", errc[1], 0);
    check_vecs(1, 256);

    // registered adder checked with LATENCY=1
    run(2, 16, 1, 1'b0, de);
    chk("wronglat_done_edge", de, 16);
    chk("wronglat_err_nz", errc[2] != 16'h0, 1);
    chk("wronglat_pass", pass[2], 0);
    run(2, 16, 1, 1'b0, de);
    chk("wronglat_rerun_err_nz", errc[2] != 16'h0, 1);

    // carry bit forced low
    run(3, 8, 1, 1'b0, de);
    chk("carry_done_edge", de, 8);
    check_vecs(3, 8);
    carries = 0;
    first_carry = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      if (({1'b0, ma[k]} + {1'b0, mb[k]}) > 9'd255) begin
        carries++;
        if (first_carry == 16'hFFFF) first_carry = k;
      end
    end
    chk("carry_err_count", errc[3], carries);
    chk("carry_first_idx", ferr[3], first_carry);
    chk("carry_pass", pass[3], (carries == 0) ? 1 : 0);

    // asynchronous reset at issue 5 of 16
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 4; u++) mstate[u] = 16'hACE1;

    run(0, 16, 1, 1'b0, de);
    chk("post_rst_done_edge", de, 16);
    chk("post_rst_pass", pass[0], 1);
    check_vecs(0, 16);
    chk("post_rst_v0_in1", cap_a[COFF], 8'hE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
